// File: rtl/minibyte_gendemux.sv
`default_nettype none
// ============================================================================
// Module      : minibyte_gendemux
// Description : 1-to-4 write demultiplexer for the minibyte write-back path.
//               It steers an 8-bit write bus into four registered destinations
//               (A/B/C/D). It supports single writes and auto-incrementing
//               bursts that wrap modulo 4. A one-hot registered load strobe
//               reports which destination changed.
//               Optional build macro: MINIBYTE_DEMUX_WRCNT_EN adds wr_cnt_out,
//               an 8-bit wrapping count of accepted write beats.
// Revision    : 1.0 - initial release
// ============================================================================
module minibyte_gendemux #(
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter int         BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic [1:0] sel_in,
    input  logic       we_in,
    input  logic       burst_in,
    input  logic       clr_in,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [7:0] c_out,
    output logic [7:0] d_out,
    output logic [3:0] ld_out,
    output logic       busy_out
`ifdef MINIBYTE_DEMUX_WRCNT_EN
    ,
    output logic [7:0] wr_cnt_out
`endif
);

    // Beat index of the final burst write. Legal BURST_LEN is 1..4, so this
    // always fits in two bits.
    localparam logic [1:0] c_last_beat = 2'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_beat;
    logic [1:0] r_base;
    logic [7:0] r_dest [4];
    logic [3:0] r_ld;
    logic       r_busy;

    logic       w_wr_en;
    logic [1:0] w_wr_idx;
    logic [3:0] w_wr_onehot;

    // A clear in the same cycle drops the write beat. In BURST the index is
    // derived from the latched base, and sel_in is ignored.
    always_comb begin
        w_wr_en     = we_in & ~clr_in;
        w_wr_idx    = (r_state == BURST) ? (r_base + r_beat) : sel_in;
        w_wr_onehot = 4'(4'b0001 << w_wr_idx);
    end

    // Destination registers: reset/clear to RESET_VAL; otherwise only the
    // addressed destination loads, and all others hold.
    always_ff @(posedge clk) begin
        if (rst || clr_in) begin
            for (int i = 0; i < 4; i++) begin
                r_dest[i] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            r_dest[w_wr_idx] <= data_in;
        end
    end

    // Control FSM with registered load strobe and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            r_base  <= 2'd0;
            r_ld    <= 4'b0000;
            r_busy  <= 1'b0;
        end else if (clr_in) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
            r_ld    <= 4'b1111;
            r_busy  <= 1'b0;
        end else begin
            r_ld <= 4'b0000;
            if (w_wr_en) begin
                r_ld <= w_wr_onehot;
                case (r_state)
                    IDLE: begin
                        if (burst_in) begin
                            r_base <= sel_in;
                            r_beat <= 2'd1;
                            // A one-beat burst is just a single write.
                            if (BURST_LEN > 1) begin
                                r_state <= BURST;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    BURST: begin
                        if (r_beat == c_last_beat) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_beat  <= 2'd0;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MINIBYTE_DEMUX_WRCNT_EN
    logic [7:0] r_wr_cnt;

    // Count accepted write beats; the clear itself is not a write.
    always_ff @(posedge clk) begin
        if (rst || clr_in) begin
            r_wr_cnt <= 8'h00;
        end else if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 8'h01;
        end
    end

    assign wr_cnt_out = r_wr_cnt;
`endif

    assign a_out    = r_dest[0];
    assign b_out    = r_dest[1];
    assign c_out    = r_dest[2];
    assign d_out    = r_dest[3];
    assign ld_out   = r_ld;
    assign busy_out = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_minibyte_gendemux.sv
`default_nettype none
// ============================================================================
// Module      : tb_minibyte_gendemux
// Description : Directed self-checking bench for minibyte_gendemux using the
//               default parameters (RESET_VAL=8'h00, BURST_LEN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_minibyte_gendemux;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [1:0] sel_in;
    logic       we_in;
    logic       burst_in;
    logic       clr_in;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [7:0] c_out;
    logic [7:0] d_out;
    logic [3:0] ld_out;
    logic       busy_out;
`ifdef MINIBYTE_DEMUX_WRCNT_EN
    logic [7:0] wr_cnt_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    minibyte_gendemux #(
        .RESET_VAL(8'h00),
        .BURST_LEN(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .sel_in  (sel_in),
        .we_in   (we_in),
        .burst_in(burst_in),
        .clr_in  (clr_in),
        .a_out   (a_out),
        .b_out   (b_out),
        .c_out   (c_out),
        .d_out   (d_out),
        .ld_out  (ld_out),
        .busy_out(busy_out)
`ifdef MINIBYTE_DEMUX_WRCNT_EN
        ,
        .wr_cnt_out(wr_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ec, input logic [7:0] ed);
        check({tag, ".a"}, 32'(a_out), 32'(ea));
        check({tag, ".b"}, 32'(b_out), 32'(eb));
        check({tag, ".c"}, 32'(c_out), 32'(ec));
        check({tag, ".d"}, 32'(d_out), 32'(ed));
    endtask

    task automatic do_reset();
        rst = 1'b1; we_in = 1'b0; burst_in = 1'b0; clr_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        data_in = 8'h00; sel_in = 2'b00; we_in = 1'b0; burst_in = 1'b0; clr_in = 1'b0;
        rst = 1'b1;

        // Reset state
        do_reset();
        check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst.ld", 32'(ld_out), 32'h0);
        check("rst.busy", 32'(busy_out), 32'h0);

        // Single write to C
        sel_in = 2'b10; data_in = 8'h5A; we_in = 1'b1;
        tick();
        check_regs("single", 8'h00, 8'h00, 8'h5A, 8'h00);
        check("single.ld", 32'(ld_out), 32'b0100);
        check("single.busy", 32'(busy_out), 32'h0);
        we_in = 1'b0;
        tick();
        check("single.ld_clr", 32'(ld_out), 32'h0);
        check("single.hold_c", 32'(c_out), 32'h5A);

        // Burst starting at D with wrap: D, A, B, C
        do_reset();
        sel_in = 2'b11; burst_in = 1'b1; we_in = 1'b1; data_in = 8'h11;
        tick();
        check("b0.d", 32'(d_out), 32'h11);
        check("b0.ld", 32'(ld_out), 32'b1000);
        check("b0.busy", 32'(busy_out), 32'h1);
        burst_in = 1'b0; sel_in = 2'b10; data_in = 8'h22;   // sel ignored in burst
        tick();
        check("b1.a", 32'(a_out), 32'h22);
        check("b1.ld", 32'(ld_out), 32'b0001);
        check("b1.busy", 32'(busy_out), 32'h1);
        data_in = 8'h33;
        tick();
        check("b2.b", 32'(b_out), 32'h33);
        check("b2.ld", 32'(ld_out), 32'b0010);
        check("b2.busy", 32'(busy_out), 32'h1);
        data_in = 8'h44;
        tick();
        check("b3.ld", 32'(ld_out), 32'b0100);
        check("b3.busy", 32'(busy_out), 32'h0);
        check_regs("burst", 8'h22, 8'h33, 8'h44, 8'h11);
        we_in = 1'b0;
        tick();
        check("burst.idle_ld", 32'(ld_out), 32'h0);

        // Burst with a two-cycle stall after the second beat
        do_reset();
        sel_in = 2'b11; burst_in = 1'b1; we_in = 1'b1; data_in = 8'h11;
        tick();
        burst_in = 1'b0; data_in = 8'h22;
        tick();
        we_in = 1'b0; data_in = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall.ld", 32'(ld_out), 32'h0);
            check("stall.busy", 32'(busy_out), 32'h1);
            check_regs("stall", 8'h22, 8'h00, 8'h00, 8'h11);
        end
        we_in = 1'b1; data_in = 8'h33;
        tick();
        check("resume.ld", 32'(ld_out), 32'b0010);
        check("resume.b", 32'(b_out), 32'h33);
        data_in = 8'h44;
        tick();
        check("resume.busy", 32'(busy_out), 32'h0);
        check_regs("stallfinal", 8'h22, 8'h33, 8'h44, 8'h11);
        we_in = 1'b0;

        // Burst starting at B: B, C, D, A
        do_reset();
        sel_in = 2'b01; burst_in = 1'b1; we_in = 1'b1; data_in = 8'hA1;
        tick();
        burst_in = 1'b0; data_in = 8'hA2;
        tick();
        data_in = 8'hA3;
        tick();
        data_in = 8'hA4;
        tick();
        check("bB.ld", 32'(ld_out), 32'b0001);
        check("bB.busy", 32'(busy_out), 32'h0);
        check_regs("bB", 8'hA4, 8'hA1, 8'hA2, 8'hA3);
        we_in = 1'b0;

        // Clear mid-burst with a concurrent write
        do_reset();
        sel_in = 2'b11; burst_in = 1'b1; we_in = 1'b1; data_in = 8'h11;
        tick();
        burst_in = 1'b0; data_in = 8'h22;
        tick();
        clr_in = 1'b1; data_in = 8'h99; sel_in = 2'b01;
        tick();
        check_regs("clr", 8'h00, 8'h00, 8'h00, 8'h00);
        check("clr.ld", 32'(ld_out), 32'b1111);
        check("clr.busy", 32'(busy_out), 32'h0);
        clr_in = 1'b0; sel_in = 2'b01; data_in = 8'h77;
        tick();
        check_regs("postclr", 8'h00, 8'h77, 8'h00, 8'h00);
        check("postclr.ld", 32'(ld_out), 32'b0010);
        check("postclr.busy", 32'(busy_out), 32'h0);
        we_in = 1'b0;

        // Mid-burst reset reverts partial writes
        do_reset();
        sel_in = 2'b00; burst_in = 1'b1; we_in = 1'b1; data_in = 8'h3C;
        tick();
        burst_in = 1'b0; data_in = 8'h4D;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; we_in = 1'b0;
        check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst.ld", 32'(ld_out), 32'h0);
        check("midrst.busy", 32'(busy_out), 32'h0);

`ifdef MINIBYTE_DEMUX_WRCNT_EN
        // Write counter wraps after 256 writes
        do_reset();
        check("cnt.rst", 32'(wr_cnt_out), 32'h0);
        we_in = 1'b1; burst_in = 1'b0;
        for (int i = 0; i < 257; i++) begin
            sel_in = 2'(i); data_in = 8'(i);
            tick();
        end
        we_in = 1'b0;
        check("cnt.257", 32'(wr_cnt_out), 32'h01);
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        check("cnt.clr", 32'(wr_cnt_out), 32'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
